// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: shadow-slot record, forward select codes
// and the source/producer match helpers.
package hazard_pkg;

   localparam int REG_ADDR_W = 5;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  we;
      logic                  load;
   } hazard_slot_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_e;

   function automatic logic slot_match(hazard_slot_t s, logic [REG_ADDR_W-1:0] rs, logic used);
      return s.valid & s.we & (s.rd == rs) & used;
   endfunction

   // Youngest producer wins: the ex slot moves to MEM by the time the consumer reaches EX.
   function automatic fwd_sel_e pick_fwd(hazard_slot_t ex, hazard_slot_t mem,
                                         logic [REG_ADDR_W-1:0] rs, logic used);
      fwd_sel_e sel;
      sel = FWD_RF;
      if (slot_match(ex, rs, used))
         sel = FWD_MEM;
      else if (slot_match(mem, rs, used))
         sel = FWD_WB;
      return sel;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-stage instruction info in, stage enables / bubbles / flushes / forward selects out.
// master = datapath side, slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
   parameter int REG_ADDR_W  = 5,
   parameter int STALL_CNT_W = 16
) ();
   logic                   id_valid;
   logic [REG_ADDR_W-1:0]  id_rs1;
   logic [REG_ADDR_W-1:0]  id_rs2;
   logic                   id_rs1_used;
   logic                   id_rs2_used;
   logic [REG_ADDR_W-1:0]  id_rd;
   logic                   id_rd_we;
   logic                   id_is_load;
   logic                   ex_redirect;
   logic                   mem_busy;
   logic                   stall_if;
   logic                   stall_id;
   logic                   bubble_ex;
   logic                   flush_if_id;
   logic                   freeze;
   logic [1:0]             fwd_a_sel;
   logic [1:0]             fwd_b_sel;
   logic [STALL_CNT_W-1:0] stall_cycles;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we, id_is_load,
             ex_redirect, mem_busy,
      input  stall_if, stall_id, bubble_ex, flush_if_id, freeze, fwd_a_sel, fwd_b_sel, stall_cycles
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_we, id_is_load,
             ex_redirect, mem_busy,
      output stall_if, stall_id, bubble_ex, flush_if_id, freeze, fwd_a_sel, fwd_b_sel, stall_cycles
   );
endinterface

// File: rtl/hazard_shadow_pipe.sv
// Three-slot shadow of in-flight destination registers (ex -> mem -> wb).
// Shifts whenever advance=1; the ex slot takes ins_slot when insert=1, otherwise an empty slot.
module hazard_shadow_pipe
   import hazard_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         advance,
   input  logic         insert,
   input  hazard_slot_t ins_slot,
   output hazard_slot_t ex_slot,
   output hazard_slot_t mem_slot,
   output hazard_slot_t wb_slot
);

   always_ff @(posedge clk) begin
      if (!reset) begin
         ex_slot  <= '0;
         mem_slot <= '0;
         wb_slot  <= '0;
      end else if (advance) begin
         wb_slot  <= mem_slot;
         mem_slot <= ex_slot;
         ex_slot  <= insert ? ins_slot : '0;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// RAW hazard, stall, flush and forward-select controller for the 5-stage pipeline.
// HAZARD_FWD_EN defined: forwarding mode, only load-use stalls; undefined: stall on any ex/mem match.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W  = 5,
   parameter int STALL_CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   pipeline_hazard_ctrl_if.slave hif
);

   logic [REG_ADDR_W-1:0]  rs1, rs2;
   logic                   ex_match, hazard, freeze, stall, ex_insert;
   logic [STALL_CNT_W-1:0] stall_cnt;
   hazard_slot_t           id_slot, ex_slot, mem_slot, wb_slot;
   logic                   unused_slot_bits;

   assign rs1 = hif.id_rs1;
   assign rs2 = hif.id_rs2;

   // wb is kept for completeness; the write-through regfile means it never stalls.
   assign unused_slot_bits = ^{wb_slot, ex_slot.load, mem_slot.load};

   always_comb begin
      id_slot       = '0;
      id_slot.valid = 1'b1;
      id_slot.rd    = hif.id_rd;
      id_slot.we    = hif.id_rd_we & (hif.id_rd != '0);
      id_slot.load  = hif.id_is_load;
   end

   assign ex_match = slot_match(ex_slot, rs1, hif.id_rs1_used)
                   | slot_match(ex_slot, rs2, hif.id_rs2_used);

`ifdef HAZARD_FWD_EN
   assign hazard = hif.id_valid & ex_match & ex_slot.load;
`else
   logic mem_match;
   assign mem_match = slot_match(mem_slot, rs1, hif.id_rs1_used)
                    | slot_match(mem_slot, rs2, hif.id_rs2_used);
   assign hazard    = hif.id_valid & (ex_match | mem_match);
`endif

   // Everything combinational is held low while reset is asserted.
   assign freeze    = reset & hif.mem_busy;
   assign stall     = reset & ((hazard & ~hif.ex_redirect) | hif.mem_busy);
   assign ex_insert = hif.id_valid & ~hazard & ~hif.ex_redirect;

   assign hif.freeze      = freeze;
   assign hif.stall_if    = stall;
   assign hif.stall_id    = stall;
   assign hif.bubble_ex   = reset & (hazard | hif.ex_redirect) & ~hif.mem_busy;
   assign hif.flush_if_id = reset & hif.ex_redirect & ~hif.mem_busy;

   hazard_shadow_pipe u_shadow (
      .clk      (clk),
      .reset    (reset),
      .advance  (~freeze),
      .insert   (ex_insert),
      .ins_slot (id_slot),
      .ex_slot  (ex_slot),
      .mem_slot (mem_slot),
      .wb_slot  (wb_slot)
   );

`ifdef HAZARD_FWD_EN
   fwd_sel_e fwd_a_d, fwd_b_d, fwd_a_q, fwd_b_q;

   assign fwd_a_d = ex_insert ? pick_fwd(ex_slot, mem_slot, rs1, hif.id_rs1_used) : FWD_RF;
   assign fwd_b_d = ex_insert ? pick_fwd(ex_slot, mem_slot, rs2, hif.id_rs2_used) : FWD_RF;

   always_ff @(posedge clk) begin
      if (!reset) begin
         fwd_a_q <= FWD_RF;
         fwd_b_q <= FWD_RF;
      end else if (!freeze) begin
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
      end
   end

   assign hif.fwd_a_sel = fwd_a_q;
   assign hif.fwd_b_sel = fwd_b_q;
`else
   assign hif.fwd_a_sel = FWD_RF;
   assign hif.fwd_b_sel = FWD_RF;
`endif

   always_ff @(posedge clk) begin
      if (!reset)
         stall_cnt <= '0;
      else if (stall && (stall_cnt != '1))
         stall_cnt <= stall_cnt + STALL_CNT_W'(1);
   end

   assign hif.stall_cycles = stall_cnt;

endmodule
